mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single SPI memory controller (ROM/RAM port) between two requesters: the control unit (instruction fetch and data accesses) and the debug/loader port. Requests are arbitrated round-robin and latched. The winning request is forwarded to the SPI controller using its existing level-start / done-rising-edge handshake. Completion is returned to the winner as a one-cycle done pulse with read data. A watchdog aborts any transaction the SPI controller never completes.

## Interface
- TIMEOUT, default 4096: maximum BUSY cycles before the transaction is aborted (range 2..65535).
- clk  in  1  system clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cu_req  in  1  CU request level; held high with cu_addr/cu_wdata/cu_we/cu_rom stable until cu_done.
- cu_addr  in  16  CU byte address.
- cu_wdata  in  8  CU write data.
- cu_we  in  1  1 = write, 0 = read.
- cu_rom  in  1  1 = ROM chip select, 0 = RAM.
- cu_done  out  1  one-cycle completion pulse to CU.
- dbg_req, dbg_addr[15:0], dbg_wdata[7:0], dbg_we, dbg_rom  in  debug port, same meaning as the cu_* inputs.
- dbg_done  out  1  one-cycle completion pulse to debug port.
- rdata  out  8  read data of the last completed transaction; shared by both ports, valid while either done is high.
- spi_executing  out  1  start/hold level to the SPI controller.
- spi_addr  out  16, spi_wdata  out  8, spi_we  out  1, spi_rom  out  1  latched transaction fields.
- spi_done  in  1  SPI controller done level; idle high, low while busy.
- spi_rdata  in  8  SPI read data, valid when spi_done rises.
- timeout_err  out  1  sticky error flag, set on watchdog abort.
- timeout_clr  in  1  clears timeout_err.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port that was not granted last.
  - On grant: latch that port's addr/wdata/we/rom into the spi_* registers, record the winner in the `last` register, clear the watchdog counter, go to BUSY.
- **BUSY**
  - spi_executing = 1.
  - spi_done_q is a register of spi_done.
  - Completion is spi_done == 1 && spi_done_q == 0. On completion: latch rdata <= spi_rdata (also on writes) and go to RESP.
  - The watchdog counter increments every BUSY cycle. If it reaches TIMEOUT - 1 with no completion: rdata <= 8'hFF, timeout_err <= 1, go to RESP.
- **RESP**
  - Winner's done = 1 for exactly this cycle; the other port's done stays 0.
  - Then go to IDLE.
- Requester rule: deassert req at the edge that ends the done cycle. A req still high in the following IDLE is a new request.
- A request dropped mid-BUSY does not abort: the transaction completes and done still pulses.
- Input changes while a port is not granted have no effect. Latched spi_* fields are stable for the whole BUSY state.
- timeout_err: timeout_clr clears it. If clear and set happen in the same cycle, set wins.
- Watchdog counter is 16 bits and never wraps; it saturates at TIMEOUT - 1.

## Timing
- Reset values:
  - state = IDLE; spi_executing = 0; cu_done = dbg_done = 0.
  - spi_addr/wdata/we/rom = 0; rdata = 0; timeout_err = 0.
  - spi_done_q = 1, so a spi_done held high after reset is not a completion.
  - last = debug, so the CU wins the first tie.
- All outputs are registered or decoded from state; no combinational path from any input to any output.
- Latency:
  - req sampled high at edge N → spi_executing high from cycle N+1.
  - Completion detected in the cycle spi_done rises (edge M) → done high in cycle M+1 → IDLE at M+2.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Reset asserted mid-BUSY: spi_executing drops immediately (asynchronously), no done pulse is issued, and no queued request is remembered.
- spi_done low at grant (controller still busy from before): the arbiter waits for the rising edge as normal.

## Test plan
- CU read, ROM, addr 16'h0012; SPI model drops spi_done 1 cycle after start, raises it 5 cycles later with rdata 8'hA5 → spi_addr = 16'h0012, spi_rom = 1, spi_we = 0; single cu_done pulse carrying rdata = 8'hA5; dbg_done stays 0.
- Both reqs high the cycle after reset → CU granted first, then debug. Repeat both continuously for 4 transactions → grant order CU, DBG, CU, DBG.
- Debug write, addr 16'h8000, wdata 8'h3C, to RAM; CU raises req while debug is in BUSY → spi_* fields unchanged during debug BUSY; CU granted only after dbg_done and one IDLE cycle.
- TIMEOUT = 8, SPI model never raises spi_done → after 8 BUSY cycles, done pulses with rdata = 8'hFF and timeout_err = 1. Pulse timeout_clr together with a second timeout → timeout_err remains 1. Then a lone timeout_clr → 0.
- Assert rst during BUSY → spi_executing goes 0 before the next clock edge; all outputs at reset values; no done pulse. Hold spi_done high after reset release → no spurious completion.
- CU drops cu_req mid-BUSY → transaction still completes and cu_done still pulses; the next IDLE with no req stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the SPI memory controller between the control unit
// and the debug/loader port, with a watchdog that aborts stalled transactions.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu_req,
  input  logic [15:0] cu_addr,
  input  logic [7:0]  cu_wdata,
  input  logic        cu_we,
  input  logic        cu_rom,
  output logic        cu_done,
  input  logic        dbg_req,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  input  logic        dbg_we,
  input  logic        dbg_rom,
  output logic        dbg_done,
  output logic [7:0]  rdata,
  output logic        spi_executing,
  output logic [15:0] spi_addr,
  output logic [7:0]  spi_wdata,
  output logic        spi_we,
  output logic        spi_rom,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic        timeout_err,
  input  logic        timeout_clr
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        last;        // 1 = debug port won the most recent grant
  logic        spi_done_q;
  logic [15:0] wd_cnt;
  logic        grant, grant_dbg;
  logic        complete, expire;

  always_comb begin
    grant     = 1'b0;
    grant_dbg = 1'b0;
    if (cu_req && dbg_req) begin
      grant     = 1'b1;
      grant_dbg = ~last;
    end else if (cu_req) begin
      grant     = 1'b1;
    end else if (dbg_req) begin
      grant     = 1'b1;
      grant_dbg = 1'b1;
    end
  end

  assign complete = spi_done && !spi_done_q;
  assign expire   = (wd_cnt == WD_LIMIT);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = BUSY;
      BUSY:    if (complete || expire) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= 1'b1;
      spi_done_q  <= 1'b1;
      wd_cnt      <= '0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
      spi_we      <= 1'b0;
      spi_rom     <= 1'b0;
      rdata       <= '0;
      timeout_err <= 1'b0;
    end else begin
      spi_done_q <= spi_done;
      if (state == IDLE && grant) begin
        last      <= grant_dbg;
        spi_addr  <= grant_dbg ? dbg_addr  : cu_addr;
        spi_wdata <= grant_dbg ? dbg_wdata : cu_wdata;
        spi_we    <= grant_dbg ? dbg_we    : cu_we;
        spi_rom   <= grant_dbg ? dbg_rom   : cu_rom;
        wd_cnt    <= '0;
      end
      // Counter only advances below the limit, so it saturates instead of wrapping.
      if (state == BUSY) begin
        if (complete)    rdata  <= spi_rdata;
        else if (expire) rdata  <= 8'hFF;
        else             wd_cnt <= wd_cnt + 16'd1;
      end
      if (state == BUSY && !complete && expire) timeout_err <= 1'b1;
      else if (timeout_clr)                     timeout_err <= 1'b0;
    end
  end

  assign spi_executing = (state == BUSY);
  assign cu_done       = (state == RESP) && !last;
  assign dbg_done      = (state == RESP) &&  last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized requesters and SPI controller, checked every
// cycle against a transaction-level model, plus directed scenarios.
module tb_mem_arbiter;

  localparam int TMO = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        rom;
  } txn_t;

  logic        clk;
  logic        rst = 1'b1;
  logic        port_req [2];
  txn_t        port_f [2];
  logic        cu_req, dbg_req;
  logic [15:0] cu_addr, dbg_addr;
  logic [7:0]  cu_wdata, dbg_wdata;
  logic        cu_we, dbg_we, cu_rom, dbg_rom;
  logic        cu_done, dbg_done;
  logic [7:0]  rdata;
  logic        spi_executing;
  logic [15:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_we, spi_rom;
  logic        spi_done;
  logic [7:0]  spi_rdata;
  logic        timeout_err;
  logic        timeout_clr;

  int checks = 0;
  int errors = 0;

  assign cu_req    = port_req[0];
  assign cu_addr   = port_f[0].addr;
  assign cu_wdata  = port_f[0].wdata;
  assign cu_we     = port_f[0].we;
  assign cu_rom    = port_f[0].rom;
  assign dbg_req   = port_req[1];
  assign dbg_addr  = port_f[1].addr;
  assign dbg_wdata = port_f[1].wdata;
  assign dbg_we    = port_f[1].we;
  assign dbg_rom   = port_f[1].rom;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cu_req(cu_req), .cu_addr(cu_addr), .cu_wdata(cu_wdata), .cu_we(cu_we),
    .cu_rom(cu_rom), .cu_done(cu_done),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
    .dbg_rom(dbg_rom), .dbg_done(dbg_done),
    .rdata(rdata), .spi_executing(spi_executing), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_we(spi_we), .spi_rom(spi_rom),
    .spi_done(spi_done), .spi_rdata(spi_rdata),
    .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction is either in flight (with an age in cycles),
  // being reported for one cycle, or absent.
  bit   m_active = 0, m_resp = 0, m_prev_done = 1, m_err = 0;
  int   m_age = 0, m_owner = 0, m_last = 1;
  logic [7:0] m_rdata = '0;
  txn_t m_f = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 0; m_resp = 0; m_prev_done = 1; m_err = 0;
      m_age = 0; m_owner = 0; m_last = 1; m_rdata = '0; m_f = '0;
    end else begin
      bit rose, set_err;
      int w;
      rose    = spi_done && !m_prev_done;
      set_err = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (m_active) begin
        m_age++;
        if (rose) begin
          m_rdata = spi_rdata; m_active = 0; m_resp = 1;
        end else if (m_age >= TMO) begin
          m_rdata = 8'hFF; set_err = 1; m_active = 0; m_resp = 1;
        end
      end else begin
        w = -1;
        if (cu_req && dbg_req) w = (m_last == 0) ? 1 : 0;
        else if (cu_req)       w = 0;
        else if (dbg_req)      w = 1;
        if (w >= 0) begin
          m_owner = w; m_last = w; m_active = 1; m_age = 0;
          m_f = (w == 0) ? txn_t'({cu_addr, cu_wdata, cu_we, cu_rom})
                         : txn_t'({dbg_addr, dbg_wdata, dbg_we, dbg_rom});
        end
      end
      if (set_err) m_err = 1;
      else if (timeout_clr) m_err = 0;
      m_prev_done = spi_done;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("spi_executing", 32'(spi_executing), 32'(m_active));
    chk("cu_done", 32'(cu_done), 32'(m_resp && m_owner == 0));
    chk("dbg_done", 32'(dbg_done), 32'(m_resp && m_owner == 1));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("spi_addr", 32'(spi_addr), 32'(m_f.addr));
    chk("spi_wdata", 32'(spi_wdata), 32'(m_f.wdata));
    chk("spi_we", 32'(spi_we), 32'(m_f.we));
    chk("spi_rom", 32'(spi_rom), 32'(m_f.rom));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  end

  // Observation of done pulses and BUSY run lengths for directed checks.
  int cu_pulses = 0, dbg_pulses = 0, busy_run = 0, last_busy = 0;
  int done_log[$];
  initial forever begin
    @(negedge clk);
    if (cu_done)  begin cu_pulses++;  done_log.push_back(0); end
    if (dbg_done) begin dbg_pulses++; done_log.push_back(1); end
    if (spi_executing) busy_run++;
    else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
  end

  // SPI controller model: drops done some cycles after start, raises it later.
  int   spi_hang = 0;   // 0 normal, 1 never raises, 2 never drops
  bit   spi_fixed = 0;
  int   fx_drop = 1, fx_busy = 1;
  logic [7:0] fx_rdata = '0;
  initial begin
    bit sp_run;
    int sp_cnt, sp_drop, sp_busy;
    logic [7:0] sp_data;
    sp_run = 0; sp_cnt = 0; sp_drop = 1; sp_busy = 1; sp_data = '0;
    spi_done = 1'b1; spi_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        spi_done = 1'b1; sp_run = 0;
      end else begin
        if (sp_run && !spi_executing) begin
          sp_run = 0; spi_done = 1'b1;
        end else if (!sp_run && spi_executing) begin
          sp_run = 1; sp_cnt = 0;
          if (spi_fixed) begin
            sp_drop = fx_drop; sp_busy = fx_busy; sp_data = fx_rdata;
          end else begin
            sp_drop = $urandom_range(1, 2); sp_busy = $urandom_range(1, 4);
            sp_data = 8'($urandom);
          end
        end
        if (sp_run) begin
          sp_cnt++;
          if (sp_cnt == sp_drop && spi_hang != 2) spi_done = 1'b0;
          if (sp_cnt == sp_drop + sp_busy && spi_hang == 0) begin
            spi_done = 1'b1; spi_rdata = sp_data;
          end
        end
      end
    end
  end

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr = 16'($urandom); t.wdata = 8'($urandom);
    t.we = 1'($urandom); t.rom = 1'($urandom);
    return t;
  endfunction

  task automatic wait_done(input int p);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((p == 0) ? cu_done : dbg_done) && n < 300);
    chk((p == 0) ? "cu_done_wait" : "dbg_done_wait",
        32'((p == 0) ? cu_done : dbg_done), 32'd1);
  endtask

  task automatic wait_exec();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!spi_executing && n < 100);
    chk("exec_wait", 32'(spi_executing), 32'd1);
  endtask

  task automatic port_run(input int p, input int n, input int max_gap);
    int gap;
    for (int k = 0; k < n; k++) begin
      port_f[p]   = rand_txn();
      port_req[p] = 1'b1;
      wait_done(p);
      @(posedge clk); #1;
      gap = $urandom_range(0, max_gap);
      if (gap != 0 || k == n - 1) begin
        port_req[p] = 1'b0;
        for (int g = 0; g < gap; g++) begin
          port_f[p] = rand_txn();
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    int c0, d0, d_cyc;
    port_req[0] = 1'b0; port_req[1] = 1'b0;
    port_f[0] = '0; port_f[1] = '0;
    timeout_clr = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_exec", 32'(spi_executing), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_addr", 32'(spi_addr), 32'd0);
    chk("reset_done", 32'({cu_done, dbg_done}), 32'd0);
    rst = 1'b0;

    // Tie straight after reset, continuous requests: CU, DBG, CU, DBG.
    done_log.delete();
    fork
      port_run(0, 2, 0);
      port_run(1, 2, 0);
    join
    chk("order_len", 32'(done_log.size()), 32'd4);
    for (int i = 0; i < done_log.size() && i < 4; i++) chk("order", 32'(done_log[i]), 32'(i % 2));

    // CU ROM read with known SPI timing.
    spi_fixed = 1; fx_drop = 1; fx_busy = 5; fx_rdata = 8'hA5;
    c0 = cu_pulses; d0 = dbg_pulses;
    port_f[0] = '{16'h0012, 8'h00, 1'b0, 1'b1}; port_req[0] = 1'b1;
    wait_done(0);
    chk("t1_rdata", 32'(rdata), 32'hA5);
    chk("t1_addr", 32'(spi_addr), 32'h0012);
    chk("t1_rom", 32'(spi_rom), 32'd1);
    chk("t1_we", 32'(spi_we), 32'd0);
    @(posedge clk); #1; port_req[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t1_cu_pulses", 32'(cu_pulses - c0), 32'd1);
    chk("t1_dbg_pulses", 32'(dbg_pulses - d0), 32'd0);

    // Debug RAM write; CU requests while debug is busy.
    spi_fixed = 0;
    port_f[1] = '{16'h8000, 8'h3C, 1'b1, 1'b0}; port_req[1] = 1'b1;
    wait_exec();
    @(posedge clk); #1;
    port_f[0] = '{16'h4321, 8'h11, 1'b0, 1'b0}; port_req[0] = 1'b1;
    wait_done(1);
    d_cyc = cyc;
    chk("t3_addr", 32'(spi_addr), 32'h8000);
    chk("t3_wdata", 32'(spi_wdata), 32'h3C);
    chk("t3_we_rom", 32'({spi_we, spi_rom}), 32'b10);
    @(posedge clk); #1; port_req[1] = 1'b0;
    wait_exec();
    chk("t3_gap", 32'(cyc - d_cyc), 32'd2);
    chk("t3_cu_addr", 32'(spi_addr), 32'h4321);
    wait_done(0);
    @(posedge clk); #1; port_req[0] = 1'b0;
    @(posedge clk); #1;

    // Watchdog abort.
    spi_hang = 1;
    port_f[0] = rand_txn(); port_req[0] = 1'b1;
    wait_done(0);
    chk("t4_rdata", 32'(rdata), 32'hFF);
    chk("t4_err", 32'(timeout_err), 32'd1);
    @(posedge clk); #1; port_req[0] = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy_len", 32'(last_busy), 32'(TMO));
    // Second abort with timeout_clr on the abort edge: set must win.
    port_f[1] = rand_txn(); port_req[1] = 1'b1;
    repeat (8) @(posedge clk); #1;
    timeout_clr = 1'b1;
    @(posedge clk); #1;
    timeout_clr = 1'b0;
    wait_done(1);
    chk("t4_set_wins", 32'(timeout_err), 32'd1);
    @(posedge clk); #1; port_req[1] = 1'b0;
    timeout_clr = 1'b1;
    @(posedge clk); #1;
    timeout_clr = 1'b0;
    @(negedge clk);
    chk("t4_cleared", 32'(timeout_err), 32'd0);
    spi_hang = 0;
    @(posedge clk); #1;

    // CU withdraws its request mid-transaction.
    spi_fixed = 1; fx_drop = 1; fx_busy = 4; fx_rdata = 8'h5A;
    c0 = cu_pulses;
    port_f[0] = rand_txn(); port_req[0] = 1'b1;
    wait_exec();
    @(posedge clk); #1; port_req[0] = 1'b0;
    wait_done(0);
    chk("t6_rdata", 32'(rdata), 32'h5A);
    repeat (4) begin
      @(negedge clk);
      chk("t6_stay_idle", 32'(spi_executing), 32'd0);
    end
    chk("t6_pulses", 32'(cu_pulses - c0), 32'd1);
    spi_fixed = 0;
    @(posedge clk); #1;

    // Randomized traffic from both ports.
    c0 = cu_pulses; d0 = dbg_pulses;
    fork
      port_run(0, 15, 3);
      port_run(1, 15, 3);
    join
    repeat (2) @(posedge clk); #1;
    chk("rand_cu_pulses", 32'(cu_pulses - c0), 32'd15);
    chk("rand_dbg_pulses", 32'(dbg_pulses - d0), 32'd15);

    // Reset during BUSY, then spi_done held high across release.
    spi_fixed = 1; fx_drop = 1; fx_busy = 4; fx_rdata = 8'h77;
    port_f[0] = rand_txn(); port_req[0] = 1'b1;
    wait_exec();
    #2 rst = 1'b1;
    #1;
    chk("t5_exec", 32'(spi_executing), 32'd0);
    chk("t5_done", 32'({cu_done, dbg_done}), 32'd0);
    chk("t5_fields", 32'({spi_addr, spi_wdata, spi_we, spi_rom}), 32'd0);
    chk("t5_rdata", 32'(rdata), 32'd0);
    chk("t5_err", 32'(timeout_err), 32'd0);
    port_req[0] = 1'b0;
    c0 = cu_pulses;
    @(posedge clk); #1;
    spi_hang = 2;
    port_f[0] = '{16'h0100, 8'h00, 1'b0, 1'b1}; port_req[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(0);
    chk("t5_no_spurious", 32'(rdata), 32'hFF);
    @(posedge clk); #1; port_req[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t5_pulses", 32'(cu_pulses - c0), 32'd1);
    spi_hang = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
